// File: rtl/msg_pkg.sv
// Shared definitions for the bot message transmitter and receiver:
// ASCII constants, message/unit encodings, frame lengths and helpers.
package msg_pkg;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_I    = 8'h49;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_U    = 8'h55;

    localparam logic [3:0] FRAME_LEN_SHORT = 4'd8;
    localparam logic [3:0] FRAME_LEN_LONG  = 4'd11;

    typedef enum logic [1:0] {
        MSG_FIM = 2'd0,
        MSG_BPM = 2'd1,
        MSG_BDM = 2'd2,
        MSG_POS = 2'd3
    } msg_type_e;

    typedef enum logic [1:0] {
        UNIT_E = 2'd0,
        UNIT_C = 2'd1,
        UNIT_R = 2'd2,
        UNIT_S = 2'd3
    } msg_unit_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_e;

    // Letter that names a unit inside a frame.
    function automatic logic [7:0] unit_char(input logic [1:0] unit);
        logic [7:0] c;
        case (msg_unit_e'(unit))
            UNIT_E:  c = ASCII_E;
            UNIT_C:  c = ASCII_C;
            UNIT_R:  c = ASCII_R;
            default: c = ASCII_S;
        endcase
        return c;
    endfunction

    // Number of bytes in a frame of the given type, '#' included.
    function automatic logic [3:0] frame_len(input logic [1:0] mtype);
        return (msg_type_e'(mtype) == MSG_BPM) ? FRAME_LEN_LONG : FRAME_LEN_SHORT;
    endfunction

    // Only the SU unit picks blocks, and it never reports faults or deposits.
    function automatic logic req_is_valid(input logic [1:0] mtype,
                                          input logic [1:0] unit,
                                          input logic [5:0] arg);
        logic ok;
        case (msg_type_e'(mtype))
            MSG_BPM: ok = (unit == UNIT_S) && (arg <= 6'd3);
            MSG_FIM: ok = (unit != UNIT_S);
            MSG_BDM: ok = (unit != UNIT_S);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/msg_tx_if.sv
// Request and UART-byte signals of the message transmitter.
//
// Handshake rules:
//   request : accepted on a cycle where msg_valid && msg_ready; the fields
//             are captured on that cycle only. msg_valid while busy is dropped.
//   uart    : tx_start is a one-cycle pulse with tx_data valid on that cycle;
//             tx_data stays stable until the next byte is loaded. tx_done is a
//             one-cycle pulse returned by the UART when the byte has gone out.
//   err     : one-cycle pulse on a rejected request or a timed-out byte.
interface msg_tx_if;
    logic       msg_valid;
    logic [1:0] msg_type;
    logic [1:0] msg_unit;
    logic [5:0] msg_arg;
    logic       msg_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       busy;
    logic       err;
    logic [2:0] state_dbg;

    modport master (
        output msg_valid, msg_type, msg_unit, msg_arg, tx_done,
        input  msg_ready, tx_data, tx_start, busy, err, state_dbg
    );

    modport slave (
        input  msg_valid, msg_type, msg_unit, msg_arg, tx_done,
        output msg_ready, tx_data, tx_start, busy, err, state_dbg
    );
endinterface

// File: rtl/msg_frame_rom.sv
// Combinational frame lookup: (type, unit, arg, index) -> ASCII byte.
module msg_frame_rom
    import msg_pkg::*;
(
    input  logic [1:0] type_i,
    input  logic [1:0] unit_i,
    input  logic [5:0] arg_i,
    input  logic [3:0] idx_i,
    output logic [7:0] byte_o
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] hdr0;
    logic [7:0] hdr1;
    logic [7:0] hdr2;
    logic [7:0] block_digit;
    logic       is_pos;
    logic       is_bpm;

    // Decimal split of the node number and the one-based block digit.
    always_comb begin
        tens        = 4'(arg_i / 6'd10);
        ones        = 4'(arg_i % 6'd10);
        block_digit = ASCII_0 + 8'd1 + {6'd0, arg_i[1:0]};
        is_pos      = (msg_type_e'(type_i) == MSG_POS);
        is_bpm      = (msg_type_e'(type_i) == MSG_BPM);
    end

    // Three-letter message mnemonic.
    always_comb begin
        hdr0 = ASCII_F;
        hdr1 = ASCII_I;
        hdr2 = ASCII_M;
        case (msg_type_e'(type_i))
            MSG_BPM: begin hdr0 = ASCII_B; hdr1 = ASCII_P; hdr2 = ASCII_M; end
            MSG_BDM: begin hdr0 = ASCII_B; hdr1 = ASCII_D; hdr2 = ASCII_M; end
            MSG_POS: begin hdr0 = ASCII_P; hdr1 = ASCII_O; hdr2 = ASCII_S; end
            default: begin hdr0 = ASCII_F; hdr1 = ASCII_I; hdr2 = ASCII_M; end
        endcase
    end

    // Byte at the requested position; positions past the frame read as 0.
    always_comb begin
        byte_o = 8'h00;
        if (idx_i < frame_len(type_i)) begin
            case (idx_i)
                4'd0:    byte_o = hdr0;
                4'd1:    byte_o = hdr1;
                4'd2:    byte_o = hdr2;
                4'd3:    byte_o = ASCII_DASH;
                4'd4:    byte_o = is_pos ? (ASCII_0 + {4'd0, tens}) : unit_char(unit_i);
                4'd5:    byte_o = is_pos ? (ASCII_0 + {4'd0, ones}) : ASCII_U;
                4'd6:    byte_o = ASCII_DASH;
                4'd7:    byte_o = is_bpm ? ASCII_B : ASCII_HASH;
                4'd8:    byte_o = block_digit;
                4'd9:    byte_o = ASCII_DASH;
                4'd10:   byte_o = ASCII_HASH;
                default: byte_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/msg_tx.sv
// Message transmitter: validates and latches one request, then feeds the
// frame byte by byte to the UART, with a per-byte timeout and a trailing gap.
module msg_tx
    import msg_pkg::*;
#(
    parameter logic [31:0] GAP_CYCLES     = 32'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000
) (
    input  logic     clk_50M,
    input  logic     reset,
    msg_tx_if.slave  bus
);

    tx_state_e   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] tout_q, tout_d;
    logic [31:0] gap_q, gap_d;
    logic [1:0]  type_q, type_d;
    logic [1:0]  unit_q, unit_d;
    logic [5:0]  arg_q, arg_d;
    logic [7:0]  data_q, data_d;
    logic        err_d;
    logic        req_ok;
    logic [7:0]  rom_byte;

    msg_frame_rom u_rom (
        .type_i (type_q),
        .unit_i (unit_q),
        .arg_i  (arg_q),
        .idx_i  (idx_q),
        .byte_o (rom_byte)
    );

    assign req_ok = req_is_valid(bus.msg_type, bus.msg_unit, bus.msg_arg);

    // Next-state and datapath updates; a byte of '#' just acknowledged ends the frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tout_d  = tout_q;
        gap_d   = gap_q;
        type_d  = type_q;
        unit_d  = unit_q;
        arg_d   = arg_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.msg_valid) begin
                    if (req_ok) begin
                        type_d  = bus.msg_type;
                        unit_d  = bus.msg_unit;
                        arg_d   = bus.msg_arg;
                        idx_d   = 4'd0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                data_d  = rom_byte;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tout_d  = 32'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done on the terminal-count cycle still wins over the timeout.
                if (bus.tx_done) begin
                    idx_d = idx_q + 4'd1;
                    if (data_q == ASCII_HASH) begin
                        gap_d   = 32'd0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (tout_q == TIMEOUT_CYCLES - 32'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tout_d = tout_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_CYCLES - 32'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            tout_q  <= 32'd0;
            gap_q   <= 32'd0;
            type_q  <= 2'd0;
            unit_q  <= 2'd0;
            arg_q   <= 6'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
            gap_q   <= gap_d;
            type_q  <= type_d;
            unit_q  <= unit_d;
            arg_q   <= arg_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode from the state; pulses are held off while reset is asserted.
    assign bus.msg_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.tx_start  = (state_q == ST_SEND) && !reset;
    assign bus.tx_data   = data_q;
    assign bus.err       = err_d && !reset;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_msg_tx.sv
// Directed bench for msg_tx with a simple UART responder model.
module tb_msg_tx;
    import msg_pkg::*;

    localparam int GAP  = 16;
    localparam int TOUT = 40;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic uart_done  = 1'b0;
    logic force_done = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor / UART model state
    int cyc           = 0;
    int uart_due      = -1000;
    bit uart_en       = 1'b0;
    int uart_delay    = 20;
    int uart_limit    = 64;
    int uart_base     = 0;
    int start_cnt     = 0;
    int err_cnt       = 0;
    int last_err_cyc  = -1;
    int ready_low_cnt = 0;
    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    logic [7:0] exp_q[$];

    msg_tx_if bus ();

    assign bus.tx_done = uart_done | force_done;

    msg_tx #(
        .GAP_CYCLES     (32'(GAP)),
        .TIMEOUT_CYCLES (32'(TOUT))
    ) dut (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Clock and cycle counter; UART done pulse driven 1 time unit after the edge.
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        uart_done = (cyc == uart_due);
    end

    // Monitor on the falling edge: records bytes, errors and ready-low cycles.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            if (uart_en && ((start_cnt - uart_base) < uart_limit))
                uart_due = cyc + uart_delay;
            got_q.push_back(bus.tx_data);
            start_cyc_q.push_back(cyc);
            start_cnt = start_cnt + 1;
        end
        if (bus.err === 1'b1) begin
            err_cnt      = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (bus.msg_ready !== 1'b1) ready_low_cnt = ready_low_cnt + 1;
    end

    task automatic send_req(input logic [1:0] t, input logic [1:0] u,
                            input logic [5:0] a, output int at_cyc);
        @(posedge clk); #2;
        bus.msg_valid = 1'b1;
        bus.msg_type  = t;
        bus.msg_unit  = u;
        bus.msg_arg   = a;
        at_cyc        = cyc;
        @(posedge clk); #2;
        bus.msg_valid = 1'b0;
        bus.msg_type  = ~t;
        bus.msg_unit  = ~u;
        bus.msg_arg   = ~a;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.msg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.msg_ready); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
        vectors++; if (bus.state_dbg !== 3'(ST_IDLE)) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    // Runs one full frame and checks bytes, latency, spacing, ready and gap timing.
    task automatic run_frame(input string name, input logic [1:0] t, input logic [1:0] u,
                             input logic [5:0] a, input logic [7:0] exp_bytes [11],
                             input int n, input int d, input bit poke);
        int acc, b_start, b_err, b_low, ld, bad, guard;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_bytes[i]);
        b_start    = start_cnt;
        b_err      = err_cnt;
        b_low      = ready_low_cnt;
        uart_delay = d;
        uart_limit = 64;
        uart_base  = start_cnt;
        uart_en    = 1'b1;
        send_req(t, u, a, acc);
        if (poke) begin
            repeat (4) @(posedge clk); #2;
            bus.msg_valid = 1'b1;
            bus.msg_type  = 2'(MSG_POS);
            bus.msg_unit  = 2'd0;
            bus.msg_arg   = 6'd11;
            @(posedge clk); #2;
            bus.msg_valid = 1'b0;
        end
        guard = 0;
        while ((start_cnt - b_start) < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if ((start_cnt - b_start) < n) begin
            miscompares++;
            $display("FAIL %s_complete: got %0d starts want %0d", name, start_cnt - b_start, n);
            return;
        end
        ld = start_cyc_q[b_start + n - 1] + d;
        while (cyc < ld + GAP) @(negedge clk);
        vectors++; if (bus.msg_ready !== 1'b0) begin miscompares++; $display("FAIL %s_ready_in_gap: got %b want 0", name, bus.msg_ready); end
        @(negedge clk);
        vectors++; if (bus.msg_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_after_gap: got %b want 1", name, bus.msg_ready); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_after_gap: got %b want 0", name, bus.busy); end
        vectors++; if ((ready_low_cnt - b_low) != (ld + GAP - acc)) begin miscompares++; $display("FAIL %s_ready_low_cycles: got %0d want %0d", name, ready_low_cnt - b_low, ld + GAP - acc); end
        repeat (4) @(negedge clk);
        vectors++; if ((start_cnt - b_start) != n) begin miscompares++; $display("FAIL %s_start_count: got %0d want %0d", name, start_cnt - b_start, n); end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (got_q[b_start + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[b_start + i], exp_q[i]);
            end
        end
        vectors++; if (start_cyc_q[b_start] != acc + 2) begin miscompares++; $display("FAIL %s_first_latency: got %0d want %0d", name, start_cyc_q[b_start] - acc, 2); end
        bad = 0;
        for (int i = 0; i + 1 < n; i++)
            if (start_cyc_q[b_start + i + 1] - start_cyc_q[b_start + i] != d + 2) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL %s_byte_spacing: got %0d bad gaps want 0", name, bad); end
        vectors++; if ((err_cnt - b_err) != 0) begin miscompares++; $display("FAIL %s_err: got %0d pulses want 0", name, err_cnt - b_err); end
        uart_en = 1'b0;
    endtask

    task automatic test_reject(input string name, input logic [1:0] t,
                               input logic [1:0] u, input logic [5:0] a);
        int acc, b_start, b_err, b_low;
        b_start = start_cnt;
        b_err   = err_cnt;
        b_low   = ready_low_cnt;
        uart_en = 1'b0;
        send_req(t, u, a, acc);
        repeat (6) @(negedge clk);
        vectors++; if ((err_cnt - b_err) != 1) begin miscompares++; $display("FAIL %s_err_pulses: got %0d want 1", name, err_cnt - b_err); end
        vectors++; if (last_err_cyc != acc) begin miscompares++; $display("FAIL %s_err_cycle: got %0d want %0d", name, last_err_cyc, acc); end
        vectors++; if ((start_cnt - b_start) != 0) begin miscompares++; $display("FAIL %s_no_start: got %0d want 0", name, start_cnt - b_start); end
        vectors++; if ((ready_low_cnt - b_low) != 0) begin miscompares++; $display("FAIL %s_ready_kept: got %0d low cycles want 0", name, ready_low_cnt - b_low); end
    endtask

    task automatic test_spurious_done();
        int b_start, b_err, b_low;
        b_start = start_cnt;
        b_err   = err_cnt;
        b_low   = ready_low_cnt;
        @(posedge clk); #2;
        force_done = 1'b1;
        @(posedge clk); #2;
        force_done = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (bus.state_dbg !== 3'(ST_IDLE)) begin miscompares++; $display("FAIL spurious_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
        vectors++; if ((start_cnt - b_start) != 0) begin miscompares++; $display("FAIL spurious_start: got %0d want 0", start_cnt - b_start); end
        vectors++; if ((err_cnt - b_err) != 0) begin miscompares++; $display("FAIL spurious_err: got %0d want 0", err_cnt - b_err); end
        vectors++; if ((ready_low_cnt - b_low) != 0) begin miscompares++; $display("FAIL spurious_ready: got %0d low cycles want 0", ready_low_cnt - b_low); end
    endtask

    task automatic test_timeout();
        int acc, b_start, b_err, guard, delta, hashes;
        b_start    = start_cnt;
        b_err      = err_cnt;
        uart_delay = 20;
        uart_limit = 3;
        uart_base  = start_cnt;
        uart_en    = 1'b1;
        send_req(2'(MSG_FIM), 2'(UNIT_C), 6'd0, acc);
        guard = 0;
        while ((err_cnt - b_err) == 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if ((err_cnt - b_err) == 0) begin
            miscompares++;
            $display("FAIL timeout_err_seen: got 0 pulses want 1");
            uart_en = 1'b0;
            return;
        end
        while (cyc < last_err_cyc + 1) @(negedge clk);
        vectors++; if (bus.msg_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_ready: got %b want 1", bus.msg_ready); end
        vectors++; if (bus.state_dbg !== 3'(ST_IDLE)) begin miscompares++; $display("FAIL timeout_state: got %0d want %0d", bus.state_dbg, ST_IDLE); end
        delta = (start_cyc_q.size() >= b_start + 4) ? (last_err_cyc - start_cyc_q[b_start + 3]) : -1;
        vectors++; if (delta != TOUT) begin miscompares++; $display("FAIL timeout_err_delay: got %0d want %0d", delta, TOUT); end
        repeat (50) @(negedge clk);
        vectors++; if ((start_cnt - b_start) != 4) begin miscompares++; $display("FAIL timeout_start_count: got %0d want 4", start_cnt - b_start); end
        vectors++; if ((err_cnt - b_err) != 1) begin miscompares++; $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - b_err); end
        hashes = 0;
        for (int i = b_start; i < start_cnt; i++) if (got_q[i] == 8'h23) hashes++;
        vectors++; if (hashes != 0) begin miscompares++; $display("FAIL timeout_no_hash: got %0d want 0", hashes); end
        uart_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int acc, b_start, guard, r, snap;
        b_start    = start_cnt;
        uart_delay = 20;
        uart_limit = 64;
        uart_base  = start_cnt;
        uart_en    = 1'b1;
        send_req(2'(MSG_BPM), 2'(UNIT_S), 6'd0, acc);
        guard = 0;
        while ((start_cnt - b_start) < 2 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        vectors++; if ((start_cnt - b_start) < 2) begin miscompares++; $display("FAIL rstmid_progress: got %0d starts want 2", start_cnt - b_start); end
        @(posedge clk); #2;
        reset = 1'b1;
        r = cyc;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (cyc != r + 1) begin miscompares++; $display("FAIL rstmid_align: got %0d want %0d", cyc, r + 1); end
        vectors++; if (bus.msg_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", bus.msg_ready); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_data: got %h want 00", bus.tx_data); end
        snap = start_cnt;
        repeat (80) @(negedge clk);
        vectors++; if (start_cnt != snap) begin miscompares++; $display("FAIL rstmid_no_start: got %0d starts want 0", start_cnt - snap); end
        uart_en = 1'b0;
    endtask

    initial begin
        logic [7:0] v [11];
        bus.msg_valid = 1'b0;
        bus.msg_type  = 2'd0;
        bus.msg_unit  = 2'd0;
        bus.msg_arg   = 6'd0;

        test_reset();

        v = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h45, 8'h55, 8'h2D, 8'h23, 8'h00, 8'h00, 8'h00};
        run_frame("fim_e", 2'(MSG_FIM), 2'(UNIT_E), 6'd0, v, 8, 20, 1'b1);

        v = '{8'h42, 8'h50, 8'h4D, 8'h2D, 8'h53, 8'h55, 8'h2D, 8'h42, 8'h33, 8'h2D, 8'h23};
        run_frame("bpm_s2", 2'(MSG_BPM), 2'(UNIT_S), 6'd2, v, 11, 20, 1'b0);

        v = '{8'h50, 8'h4F, 8'h53, 8'h2D, 8'h34, 8'h32, 8'h2D, 8'h23, 8'h00, 8'h00, 8'h00};
        run_frame("pos_42", 2'(MSG_POS), 2'd0, 6'd42, v, 8, 20, 1'b0);

        test_spurious_done();

        v = '{8'h50, 8'h4F, 8'h53, 8'h2D, 8'h30, 8'h37, 8'h2D, 8'h23, 8'h00, 8'h00, 8'h00};
        run_frame("pos_7", 2'(MSG_POS), 2'd1, 6'd7, v, 8, 20, 1'b0);

        test_reject("rej_bpm_e", 2'(MSG_BPM), 2'(UNIT_E), 6'd1);
        test_reject("rej_fim_s", 2'(MSG_FIM), 2'(UNIT_S), 6'd0);
        test_reject("rej_bpm_arg5", 2'(MSG_BPM), 2'(UNIT_S), 6'd5);

        // tx_done lands on the timeout terminal-count cycle of every byte
        v = '{8'h42, 8'h44, 8'h4D, 8'h2D, 8'h43, 8'h55, 8'h2D, 8'h23, 8'h00, 8'h00, 8'h00};
        run_frame("bdm_c_edge", 2'(MSG_BDM), 2'(UNIT_C), 6'd0, v, 8, TOUT, 1'b0);

        test_timeout();
        test_reset_mid_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
